// File: rtl/rgmii_tx_rate_adapter.sv
// RGMII transmit rate adapter: paces tx_mac bytes into ODDR rise/fall pairs at 1G/100M/10M.
// Optional error-byte counter port tx_err_count is enabled by defining RGMII_TX_ERR_CNT_EN.
module rgmii_tx_rate_adapter #(
    parameter int DATA_WIDTH       = 8,
    parameter int RGMII_DATA_WIDTH = 4,
    parameter int P100             = 5,
    parameter int P10              = 50
) (
    input  logic                        clk_125,
    input  logic                        reset,
    input  logic [1:0]                  link_speed,
    input  logic [DATA_WIDTH-1:0]       s_tx_data,
    input  logic                        s_tx_dv,
    input  logic                        s_tx_er,
    output logic                        s_tx_rdy,
    output logic                        txc_rise,
    output logic                        txc_fall,
    output logic [RGMII_DATA_WIDTH-1:0] txd_rise,
    output logic [RGMII_DATA_WIDTH-1:0] txd_fall,
    output logic                        txctl_rise,
    output logic                        txctl_fall
`ifdef RGMII_TX_ERR_CNT_EN
    ,
    output logic [15:0]                 tx_err_count
`endif
);

    typedef enum logic [1:0] {ST_GIG, ST_MII, ST_RESYNC} state_t;

    localparam logic [5:0] P100_LAST = 6'(P100 - 1);
    localparam logic [5:0] P10_LAST  = 6'(P10 - 1);
    localparam logic [5:0] HALF100   = 6'((P100 + 1) / 2);
    localparam logic [5:0] HALF10    = 6'((P10 + 1) / 2);

    state_t                        state_q, state_d;
    logic [5:0]                    phase_q, phase_d;
    logic                          nib_sel_q, nib_sel_d;
    logic [1:0]                    spd_q, spd_d;
    logic                          in_frame_q, in_frame_d;
    logic [RGMII_DATA_WIDTH-1:0]   hi_q, hi_d;
    logic                          rdy_q, rdy_d;
    logic                          txc_rise_q, txc_rise_d;
    logic                          txc_fall_q, txc_fall_d;
    logic [RGMII_DATA_WIDTH-1:0]   txd_rise_q, txd_rise_d;
    logic [RGMII_DATA_WIDTH-1:0]   txd_fall_q, txd_fall_d;
    logic                          ctl_rise_q, ctl_rise_d;
    logic                          ctl_fall_q, ctl_fall_d;

    logic [DATA_WIDTH-1:0]         data_m;
    logic [1:0]                    spd_norm;
    logic [5:0]                    p_last, half, half_m1;

    assign p_last  = spd_q[0] ? P100_LAST : P10_LAST;
    assign half    = spd_q[0] ? HALF100 : HALF10;
    assign half_m1 = half - 6'd1;

    always_comb begin
        data_m     = s_tx_dv ? s_tx_data : '0;
        spd_norm   = (link_speed == 2'b11) ? 2'b10 : link_speed;
        // Including this cycle's accepted byte keeps a frame's first byte from being lost to a resync.
        in_frame_d = rdy_q ? s_tx_dv : in_frame_q;
        spd_d      = in_frame_d ? spd_q : spd_norm;

        state_d    = state_q;
        phase_d    = phase_q;
        nib_sel_d  = nib_sel_q;
        hi_d       = hi_q;
        txd_rise_d = txd_rise_q;
        txd_fall_d = txd_fall_q;
        ctl_rise_d = ctl_rise_q;
        ctl_fall_d = ctl_fall_q;

        if (spd_d != spd_q) begin
            state_d    = ST_RESYNC;
            phase_d    = '0;
            nib_sel_d  = 1'b1;
            txd_rise_d = '0;
            txd_fall_d = '0;
            ctl_rise_d = 1'b0;
            ctl_fall_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_GIG: begin
                    txd_rise_d = rdy_q ? data_m[RGMII_DATA_WIDTH-1:0] : '0;
                    txd_fall_d = rdy_q ? data_m[DATA_WIDTH-1:RGMII_DATA_WIDTH] : '0;
                    ctl_rise_d = rdy_q & s_tx_dv;
                    ctl_fall_d = rdy_q & s_tx_dv & ~s_tx_er;
                end
                ST_MII: begin
                    phase_d = (phase_q == p_last) ? 6'd0 : phase_q + 6'd1;
                    // Nibbles change just after TXC falls so each one straddles the next rising edge.
                    if (phase_q == half_m1) begin
                        nib_sel_d = ~nib_sel_q;
                        if (rdy_q) begin
                            txd_rise_d = data_m[RGMII_DATA_WIDTH-1:0];
                            txd_fall_d = data_m[RGMII_DATA_WIDTH-1:0];
                            hi_d       = data_m[DATA_WIDTH-1:RGMII_DATA_WIDTH];
                            ctl_rise_d = s_tx_dv;
                            ctl_fall_d = s_tx_dv & ~s_tx_er;
                        end else begin
                            txd_rise_d = hi_q;
                            txd_fall_d = hi_q;
                        end
                    end
                end
                ST_RESYNC: begin
                    state_d    = spd_q[1] ? ST_GIG : ST_MII;
                    phase_d    = '0;
                    nib_sel_d  = 1'b1;
                    txd_rise_d = '0;
                    txd_fall_d = '0;
                    ctl_rise_d = 1'b0;
                    ctl_fall_d = 1'b0;
                end
                default: state_d = ST_RESYNC;
            endcase
        end

        rdy_d      = (state_d == ST_GIG) ||
                     ((state_d == ST_MII) && (phase_d == half_m1) && nib_sel_d);
        txc_rise_d = (state_d == ST_GIG) || ((state_d == ST_MII) && (phase_d < half));
        txc_fall_d = (state_d == ST_MII) && (phase_d < half);
    end

    always_ff @(posedge clk_125) begin
        if (reset) begin
            state_q    <= ST_GIG;
            phase_q    <= '0;
            nib_sel_q  <= 1'b0;
            spd_q      <= 2'b10;
            in_frame_q <= 1'b0;
            hi_q       <= '0;
            rdy_q      <= 1'b0;
            txc_rise_q <= 1'b0;
            txc_fall_q <= 1'b0;
            txd_rise_q <= '0;
            txd_fall_q <= '0;
            ctl_rise_q <= 1'b0;
            ctl_fall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            nib_sel_q  <= nib_sel_d;
            spd_q      <= spd_d;
            in_frame_q <= in_frame_d;
            hi_q       <= hi_d;
            rdy_q      <= rdy_d;
            txc_rise_q <= txc_rise_d;
            txc_fall_q <= txc_fall_d;
            txd_rise_q <= txd_rise_d;
            txd_fall_q <= txd_fall_d;
            ctl_rise_q <= ctl_rise_d;
            ctl_fall_q <= ctl_fall_d;
        end
    end

    assign s_tx_rdy   = rdy_q;
    assign txc_rise   = txc_rise_q;
    assign txc_fall   = txc_fall_q;
    assign txd_rise   = txd_rise_q;
    assign txd_fall   = txd_fall_q;
    assign txctl_rise = ctl_rise_q;
    assign txctl_fall = ctl_fall_q;

`ifdef RGMII_TX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rdy_q && s_tx_dv && s_tx_er && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_125) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign tx_err_count = err_cnt_q;
`endif

endmodule
